// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared constants and types for the reaction timer score display.
// Contents:
//   - timer state encodings carried on the iSTATE bus
//   - active-high 7-segment constants (bit 6 = g ... bit 0 = a)
//   - digit count / value width
//   - converter FSM state type and encodings
//   - dabble_adjust(): the add-3 correction applied to every BCD nibble
// -----------------------------------------------------------------------------
package display_pkg;

    localparam int VALUE_W    = 14;
    localparam int BCD_DIGITS = 4;
    localparam int BCD_W      = 4 * BCD_DIGITS;

    // Timer state encodings driven by the upstream reaction timer
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_TIMING = 2'd2;
    localparam logic [1:0] ST_SHOW   = 2'd3;

    // Segment patterns in active-high form, {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    // Binary-to-BCD converter FSM
    typedef logic [1:0] conv_state_t;
    localparam conv_state_t CV_IDLE  = 2'd0;
    localparam conv_state_t CV_SHIFT = 2'd1;
    localparam conv_state_t CV_LATCH = 2'd2;

    // Double-dabble correction: any nibble >= 5 gets +3 before the shift so
    // that the shift carries correctly into the next decimal digit.
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end else begin
                res[4*i +: 4] = bcd[4*i +: 4];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Purely combinational BCD nibble to 7-segment pattern, active-high.
// Ports:
//   iNIBBLE  in  4  BCD digit 0-9 (10-15 decode to blank)
//   iBLANK   in  1  force the digit dark (leading-zero suppression)
//   oSEG     out 7  segments {g,f,e,d,c,b,a}, 1 = segment lit
// -----------------------------------------------------------------------------
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] iNIBBLE,
    input  logic       iBLANK,
    output logic [6:0] oSEG
);

    // Digit pattern lookup
    always_comb begin
        oSEG = SEG_BLANK;
        if (iBLANK) begin
            oSEG = SEG_BLANK;
        end else begin
            case (iNIBBLE)
                4'd0:    oSEG = 7'h3F;
                4'd1:    oSEG = 7'h06;
                4'd2:    oSEG = 7'h5B;
                4'd3:    oSEG = 7'h4F;
                4'd4:    oSEG = 7'h66;
                4'd5:    oSEG = 7'h6D;
                4'd6:    oSEG = 7'h7D;
                4'd7:    oSEG = 7'h07;
                4'd8:    oSEG = 7'h7F;
                4'd9:    oSEG = 7'h6F;
                default: oSEG = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/reaction_score_display.sv
// -----------------------------------------------------------------------------
// reaction_score_display
// Takes the reaction timer's millisecond count and state, converts the count
// to BCD with a one-bit-per-clock double-dabble engine and drives four
// 7-segment digits.
// Parameters:
//   COMMON_ANODE  1 = segments active-low on the pins, 0 = active-high
//   MAX_VALUE     input values above this are clamped before conversion
// Ports:
//   iCLK          in   1   system clock
//   iRST          in   1   synchronous, active-high reset
//   iVALUE        in   14  count to display
//   iSTATE        in   2   timer state (1 = WAIT_DELAY shows dashes)
//   oHEX0..oHEX3  out  7   segments {g,f,e,d,c,b,a}; oHEX0 = ones digit
//   oBCD          out  16  {thousands, hundreds, tens, ones}
//   oBUSY         out  1   conversion in progress
//   oDONE         out  1   one-cycle pulse when oBCD updates
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, leading zero digits (thousands,
//                          hundreds, tens) are blanked; ones always shown.
// -----------------------------------------------------------------------------
module reaction_score_display
    import display_pkg::*;
#(
    parameter bit          COMMON_ANODE = 1'b1,
    parameter int unsigned MAX_VALUE    = 9999
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic [VALUE_W-1:0] iVALUE,
    input  logic [1:0]         iSTATE,
    output logic [6:0]         oHEX0,
    output logic [6:0]         oHEX1,
    output logic [6:0]         oHEX2,
    output logic [6:0]         oHEX3,
    output logic [BCD_W-1:0]   oBCD,
    output logic               oBUSY,
    output logic               oDONE
);

    localparam logic [VALUE_W-1:0] MAX_V    = VALUE_W'(MAX_VALUE);
    // XOR mask turning the active-high pattern into pin polarity
    localparam logic [6:0]         POL_MASK = COMMON_ANODE ? 7'h7F : 7'h00;

    conv_state_t        state_q, state_d;
    logic [VALUE_W-1:0] shreg_q, shreg_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [VALUE_W-1:0] load_q, load_d;
    logic [VALUE_W-1:0] last_q, last_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [6:0]         hex_q [BCD_DIGITS];
    logic [6:0]         hex_d [BCD_DIGITS];

    logic [VALUE_W-1:0] clamped_s;
    logic [BCD_W-1:0]   adj_s;
    logic [6:0]         seg_s   [BCD_DIGITS];
    logic               blank_s [BCD_DIGITS];

    assign clamped_s = (iVALUE > MAX_V) ? MAX_V : iVALUE;
    assign adj_s     = dabble_adjust(scratch_q);

    // Converter FSM next-state and datapath
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        load_d    = load_q;
        last_d    = last_q;
        bcd_d     = bcd_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            CV_IDLE: begin
                // Changes seen while busy are picked up here, so the last
                // stable value always ends up on the display.
                if (clamped_s != last_q) begin
                    shreg_d   = clamped_s;
                    load_d    = clamped_s;
                    scratch_d = {BCD_W{1'b0}};
                    cnt_d     = 4'd0;
                    busy_d    = 1'b1;
                    state_d   = CV_SHIFT;
                end else begin
                    busy_d    = 1'b0;
                    state_d   = CV_IDLE;
                end
            end
            CV_SHIFT: begin
                scratch_d = {adj_s[BCD_W-2:0], shreg_q[VALUE_W-1]};
                shreg_d   = {shreg_q[VALUE_W-2:0], 1'b0};
                cnt_d     = cnt_q + 4'd1;
                if (cnt_q == 4'(VALUE_W - 1)) begin
                    state_d = CV_LATCH;
                end else begin
                    state_d = CV_SHIFT;
                end
            end
            CV_LATCH: begin
                bcd_d   = scratch_q;
                last_d  = load_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = CV_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = CV_IDLE;
            end
        endcase
    end

    // Leading-zero suppression flags for thousands, hundreds and tens
    always_comb begin
        blank_s[0] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        blank_s[3] = (bcd_q[15:12] == 4'd0);
        blank_s[2] = blank_s[3] && (bcd_q[11:8] == 4'd0);
        blank_s[1] = blank_s[2] && (bcd_q[7:4] == 4'd0);
`else
        blank_s[3] = 1'b0;
        blank_s[2] = 1'b0;
        blank_s[1] = 1'b0;
`endif
    end

    genvar g;
    generate
        for (g = 0; g < BCD_DIGITS; g++) begin : g_dec
            seg7_decode u_dec (
                .iNIBBLE (bcd_q[4*g +: 4]),
                .iBLANK  (blank_s[g]),
                .oSEG    (seg_s[g])
            );
        end
    endgenerate

    // Segment select: dashes while waiting for the random delay, else digits
    always_comb begin
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (iSTATE == ST_WAIT) begin
                hex_d[i] = SEG_DASH ^ POL_MASK;
            end else begin
                hex_d[i] = seg_s[i] ^ POL_MASK;
            end
        end
    end

    // State and output registers
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q   <= CV_IDLE;
            shreg_q   <= {VALUE_W{1'b0}};
            scratch_q <= {BCD_W{1'b0}};
            cnt_q     <= 4'd0;
            load_q    <= {VALUE_W{1'b0}};
            last_q    <= {VALUE_W{1'b0}};
            bcd_q     <= {BCD_W{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            for (int i = 0; i < BCD_DIGITS; i++) begin
                hex_q[i] <= SEG_BLANK ^ POL_MASK;
            end
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            load_q    <= load_d;
            last_q    <= last_d;
            bcd_q     <= bcd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            for (int i = 0; i < BCD_DIGITS; i++) begin
                hex_q[i] <= hex_d[i];
            end
        end
    end

    assign oHEX0 = hex_q[0];
    assign oHEX1 = hex_q[1];
    assign oHEX2 = hex_q[2];
    assign oHEX3 = hex_q[3];
    assign oBCD  = bcd_q;
    assign oBUSY = busy_q;
    assign oDONE = done_q;

endmodule
